dm_byte_mem: RTL and testbench

//   Parametrised, byte-addressable data memory for the MIPS datapath; the next

---
 rtl/dm_byte_mem.sv | 153 +++++++++++++++
 tb/tb_dm_byte_mem.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_byte_mem.sv
// Byte-addressable data memory with byte/half/word loads and stores,
// sign/zero extension, misalignment detection and post-reset zero fill.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   req_valid/req_ready request handshake (no back-pressure once idle)
//   req_we              1 = store, 0 = load
//   req_size            00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned        loads: 1 = zero-extend, 0 = sign-extend
//   req_addr            byte address
//   req_wdata           right-aligned store data
//   rsp_valid           one-cycle pulse following each accepted request
//   rsp_rdata           extended load data (0 for stores and errors)
//   rsp_err             misaligned access or illegal size
module dm_byte_mem #(
    parameter int ADDR_W    = 12,
    parameter bit INIT_ZERO = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int WW    = ADDR_W - 2;
    localparam int DEPTH = 1 << WW;

    typedef enum logic {
        S_INIT,
        S_IDLE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [WW-1:0] cnt;
    logic          init_we;

    logic [31:0]   mem [DEPTH];

    logic          accept;
    logic [1:0]    lane;
    logic [WW-1:0] widx;
    logic          err;
    logic [3:0]    be;
    logic [31:0]   wd;
    logic [31:0]   rword;
    logic [31:0]   sh;
    logic [31:0]   ld;
    logic          valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= INIT_ZERO ? S_INIT : S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (init_we) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        init_we   = 1'b0;
        if (state == S_INIT) begin
            init_we = 1'b1;
            if (&cnt) begin
                state_nxt = S_IDLE;
            end
        end
    end

    // Gated by rst so nothing is offered or reported during a reset cycle.
    assign req_ready = (state == S_IDLE) & ~rst;
    assign accept    = req_valid & req_ready;
    assign rsp_valid = valid_q & ~rst;

    always_comb begin
        lane = req_addr[1:0];
        widx = req_addr[ADDR_W-1:2];
        err  = 1'b0;
        be   = 4'b0000;
        wd   = req_wdata;
        case (req_size)
            2'b00: begin
                be = 4'b0001 << lane;
                wd = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                err = lane[0];
                be  = lane[1] ? 4'b1100 : 4'b0011;
                wd  = {2{req_wdata[15:0]}};
            end
            2'b10: begin
                err = |lane;
                be  = 4'b1111;
            end
            default: err = 1'b1;
        endcase
        if (err) begin
            be = 4'b0000;
        end
    end

    // Shift the addressed lane down to bit 0, then extend.
    always_comb begin
        rword = mem[widx];
        sh    = rword >> {lane, 3'b000};
        case (req_size)
            2'b00: ld = req_unsigned ? {24'h0, sh[7:0]}
                                     : {{24{sh[7]}}, sh[7:0]};
            2'b01: ld = req_unsigned ? {16'h0, sh[15:0]}
                                     : {{16{sh[15]}}, sh[15:0]};
            default: ld = sh;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst && init_we) begin
            mem[cnt] <= 32'h0;
        end else if (accept && req_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[widx][8*i +: 8] <= wd[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
        end else begin
            valid_q <= accept;
            if (accept) begin
                rsp_err   <= err;
                rsp_rdata <= (req_we || err) ? 32'h0 : ld;
            end
        end
    end

endmodule

// File: tb/tb_dm_byte_mem.sv
// Testbench for dm_byte_mem: byte-array reference model, per-cycle
// comparator, directed literal checks and a randomized request stream.
module tb_dm_byte_mem;

    localparam int AW    = 6;
    localparam int DEPTH = 16;
    localparam int NB    = 64;

    logic          clk;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [1:0]    req_size;
    logic          req_unsigned;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;

    int tests = 0;
    int fails = 0;
    bit check_en = 1'b0;

    dm_byte_mem #(
        .ADDR_W   (AW),
        .INIT_ZERO(1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_size    (req_size),
        .req_unsigned(req_unsigned),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %08h expected %08h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Reference model: memory as a flat byte array.
    logic [7:0]  mm [NB];
    bit          m_ready;
    int          init_left;
    bit          m_valid;
    logic [31:0] m_rdata;
    bit          m_err;

    function automatic bit is_err(input logic [1:0] sz, input int a);
        if (sz == 2'b11) return 1'b1;
        return (a % (1 << sz)) != 0;
    endfunction

    function automatic logic [31:0] ld_val(input logic [1:0] sz,
                                           input bit uns, input int a);
        int n;
        logic [31:0] v;
        n = 1 << sz;
        v = 32'h0;
        for (int k = 0; k < n; k++) v[8*k +: 8] = mm[(a + k) % NB];
        if (n < 4 && !uns && v[8*n-1])
            for (int k = n; k < 4; k++) v[8*k +: 8] = 8'hFF;
        return v;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_ready   <= 1'b0;
            init_left <= DEPTH;
            m_valid   <= 1'b0;
            m_rdata   <= 32'h0;
            m_err     <= 1'b0;
        end else if (!m_ready) begin
            for (int k = 0; k < 4; k++)
                mm[(DEPTH - init_left) * 4 + k] <= 8'h00;
            init_left <= init_left - 1;
            m_ready   <= (init_left == 1);
            m_valid   <= 1'b0;
        end else begin
            m_valid <= req_valid;
            if (req_valid) begin
                m_err <= is_err(req_size, int'(req_addr));
                if (req_we || is_err(req_size, int'(req_addr)))
                    m_rdata <= 32'h0;
                else
                    m_rdata <= ld_val(req_size, req_unsigned, int'(req_addr));
                if (req_we && !is_err(req_size, int'(req_addr)))
                    for (int k = 0; k < (1 << req_size); k++)
                        mm[(int'(req_addr) + k) % NB] <= req_wdata[8*k +: 8];
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("ready", 32'(req_ready), 32'(m_ready && !rst));
            chk("rsp_valid", 32'(rsp_valid), 32'(m_valid && !rst));
            chk("rsp_rdata", rsp_rdata, m_rdata);
            chk("rsp_err", 32'(rsp_err), 32'(m_err));
        end
    end

    task automatic drive(input bit we, input logic [1:0] sz, input bit uns,
                         input logic [AW-1:0] a, input logic [31:0] wd);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = a;
        req_wdata    = wd;
    endtask

    // Issue one request and check its response against literals.
    task automatic lit(input string nm, input bit we, input logic [1:0] sz,
                       input bit uns, input logic [AW-1:0] a,
                       input logic [31:0] wd, input logic [31:0] exp,
                       input bit exp_err);
        drive(we, sz, uns, a, wd);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk({nm, ".valid"}, 32'(rsp_valid), 32'd1);
        chk({nm, ".rdata"}, rsp_rdata, exp);
        chk({nm, ".err"}, 32'(rsp_err), 32'(exp_err));
        @(posedge clk); #1;
    endtask

    task automatic init_wait(input string nm);
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            chk(nm, 32'(req_ready), 32'd0);
        end
        @(negedge clk);
        chk(nm, 32'(req_ready), 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        int pulses;
        logic [1:0] sz;
        int a;
        rst          = 1'b1;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = 32'h0;

        repeat (3) @(posedge clk);
        #1;
        check_en = 1'b1;
        chk("reset.valid", 32'(rsp_valid), 32'd0);
        chk("reset.rdata", rsp_rdata, 32'h0);
        chk("reset.err", 32'(rsp_err), 32'd0);
        rst = 1'b0;
        init_wait("init_ready");
        lit("init_lw3c", 1'b0, 2'b10, 1'b0, 6'h3C, 0, 32'h0, 1'b0);

        lit("sw10", 1'b1, 2'b10, 1'b0, 6'h10, 32'h12345678, 32'h0, 1'b0);
        lit("lb10", 1'b0, 2'b00, 1'b0, 6'h10, 0, 32'h00000078, 1'b0);
        lit("lb13", 1'b0, 2'b00, 1'b0, 6'h13, 0, 32'h00000012, 1'b0);
        lit("lbu13", 1'b0, 2'b00, 1'b1, 6'h13, 0, 32'h00000012, 1'b0);
        lit("lh12", 1'b0, 2'b01, 1'b0, 6'h12, 0, 32'h00001234, 1'b0);
        lit("lhu10", 1'b0, 2'b01, 1'b1, 6'h10, 0, 32'h00005678, 1'b0);

        lit("sw20", 1'b1, 2'b10, 1'b0, 6'h20, 32'h0, 32'h0, 1'b0);
        lit("sb21", 1'b1, 2'b00, 1'b0, 6'h21, 32'h000000AB, 32'h0, 1'b0);
        lit("sh22", 1'b1, 2'b01, 1'b0, 6'h22, 32'h0000BEEF, 32'h0, 1'b0);
        lit("lw20", 1'b0, 2'b10, 1'b0, 6'h20, 0, 32'hBEEFAB00, 1'b0);
        lit("lb21", 1'b0, 2'b00, 1'b0, 6'h21, 0, 32'hFFFFFFAB, 1'b0);
        lit("lh22", 1'b0, 2'b01, 1'b0, 6'h22, 0, 32'hFFFFBEEF, 1'b0);

        lit("sw05", 1'b1, 2'b10, 1'b0, 6'h05, 32'hFFFFFFFF, 32'h0, 1'b1);
        lit("lw04", 1'b0, 2'b10, 1'b0, 6'h04, 0, 32'h0, 1'b0);
        lit("lh03", 1'b0, 2'b01, 1'b0, 6'h03, 0, 32'h0, 1'b1);
        lit("size3", 1'b0, 2'b11, 1'b0, 6'h00, 0, 32'h0, 1'b1);

        drive(1'b1, 2'b10, 1'b0, 6'h08, 32'hCAFEF00D);
        @(posedge clk); #1;
        drive(1'b0, 2'b10, 1'b0, 6'h08, 32'h0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("b2b.valid", 32'(rsp_valid), 32'd1);
        chk("b2b.rdata", rsp_rdata, 32'hCAFEF00D);
        @(posedge clk); #1;

        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 2'b10, 1'b0, AW'(4 * i), 32'h0);
            @(posedge clk); #1;
            if (rsp_valid) pulses++;
        end
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("stream.pulses", 32'(pulses), 32'd8);
        chk("stream.after", 32'(rsp_valid), 32'd0);

        drive(1'b0, 2'b10, 1'b0, 6'h08, 32'h0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid.valid", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        init_wait("reinit_ready");
        lit("reinit_lw08", 1'b0, 2'b10, 1'b0, 6'h08, 0, 32'h0, 1'b0);

        for (int i = 0; i < 800; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            sz = ($urandom_range(0, 9) == 0) ? 2'b11
                                             : 2'($urandom_range(0, 2));
            a = $urandom_range(0, NB - 1);
            if (sz != 2'b11 && $urandom_range(0, 3) != 0)
                a = a & ~((1 << sz) - 1);
            drive(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
                  AW'(a), $urandom);
            req_valid = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        rst = 1'b0;
        req_valid = 1'b0;
        repeat (DEPTH + 4) @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
